evm_multi_candidate: RTL and testbench

//  Parametrised successor of the 3-candidate voting core: N candidates, configurable counter width,
//  one-vote-per-arming ballot control, multi-press rejection, saturating tallies and a sequential

---
 rtl/evm_multi_candidate.sv | 201 ++++++++++++++++++++
 tb/tb_evm_multi_candidate.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/evm_multi_candidate.sv
`default_nettype none
// ============================================================================
// Module      : evm_multi_candidate
// Description : N-candidate electronic voting core. One vote is accepted per
//               officer arming, multi-press ballots are rejected with a
//               one-cycle pulse, tallies saturate, and a winner/tie scan over
//               the tallies runs one candidate per cycle after polling closes.
// Revision    : 1.0 - initial release
// ============================================================================
module evm_multi_candidate #(
  parameter  int NUM_CAND = 4,
  parameter  int CNT_W    = 8,
  localparam int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_switch_on,
  input  logic                i_switch_off,
  input  logic                i_ballot_arm,
  input  logic [NUM_CAND-1:0] i_vote_btn,
  input  logic                i_session_done,
  input  logic [IDX_W-1:0]    i_disp_sel,
  output logic [CNT_W-1:0]    o_result_cnt,
  output logic [IDX_W-1:0]    o_winner_idx,
  output logic                o_winner_valid,
  output logic                o_tie,
  output logic                o_invalid_vote,
  output logic                o_overflow,
  output logic                o_voting_in_progress,
  output logic                o_ballot_armed,
  output logic                o_voting_done
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [NUM_CAND-1:0] c_VOTE_ONE = NUM_CAND'(1);
  localparam logic [IDX_W-1:0]    c_LAST_IDX = IDX_W'(NUM_CAND - 1);
  localparam logic [IDX_W:0]      c_NUM_EXT  = (IDX_W + 1)'(NUM_CAND);
  localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt [NUM_CAND];
  logic               r_overflow;
  logic               r_invalid;
  logic [CNT_W-1:0]   r_result;
  logic               r_in_progress;
  logic               r_armed;
  logic               r_done;
  // Scan working registers
  logic               r_scanning;
  logic [IDX_W-1:0]   r_scan_idx;
  logic [IDX_W-1:0]   r_best_idx;
  logic [CNT_W-1:0]   r_best_val;
  logic               r_tie_acc;
  // Published scan result
  logic               r_winner_valid;
  logic [IDX_W-1:0]   r_winner_idx;
  logic               r_tie;

  logic               w_multi;
  logic               w_onehot;
  logic               w_disp_ok;
  logic [CNT_W-1:0]   w_scan_val;
  logic               w_take;
  logic [IDX_W-1:0]   w_nxt_best_idx;
  logic [CNT_W-1:0]   w_nxt_best_val;
  logic               w_nxt_tie;

  // Ballot classification and next scan step; x & (x-1) is non-zero iff >=2 bits set
  always_comb begin
    w_multi        = |(i_vote_btn & (i_vote_btn - c_VOTE_ONE));
    w_onehot       = (i_vote_btn != '0) && !w_multi;
    w_disp_ok      = ({1'b0, i_disp_sel} < c_NUM_EXT);
    w_scan_val     = r_cnt[r_scan_idx];
    // Candidate 0 always seeds the best; later ones must be strictly greater
    w_take         = (r_scan_idx == '0) || (w_scan_val > r_best_val);
    w_nxt_best_idx = w_take ? r_scan_idx : r_best_idx;
    w_nxt_best_val = w_take ? w_scan_val : r_best_val;
    w_nxt_tie      = w_take ? 1'b0 : (r_tie_acc || (w_scan_val == r_best_val));
  end

  // Ballot FSM, tallies, winner scan and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_OFF;
      for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
      r_overflow     <= 1'b0;
      r_invalid      <= 1'b0;
      r_result       <= '0;
      r_in_progress  <= 1'b0;
      r_armed        <= 1'b0;
      r_done         <= 1'b0;
      r_scanning     <= 1'b0;
      r_scan_idx     <= '0;
      r_best_idx     <= '0;
      r_best_val     <= '0;
      r_tie_acc      <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner_idx   <= '0;
      r_tie          <= 1'b0;
    end else begin
      r_invalid <= 1'b0;
      r_result  <= '0;
      if (i_switch_off) begin
        // Power down: tallies are kept but everything visible is cleared
        r_state        <= ST_OFF;
        r_in_progress  <= 1'b0;
        r_armed        <= 1'b0;
        r_done         <= 1'b0;
        r_scanning     <= 1'b0;
        r_winner_valid <= 1'b0;
        r_winner_idx   <= '0;
        r_tie          <= 1'b0;
      end else begin
        case (r_state)
          ST_OFF: begin
            if (i_switch_on) begin
              r_state        <= ST_IDLE;
              r_in_progress  <= 1'b1;
              for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
              r_overflow     <= 1'b0;
              r_scanning     <= 1'b0;
              r_scan_idx     <= '0;
              r_best_idx     <= '0;
              r_best_val     <= '0;
              r_tie_acc      <= 1'b0;
              r_winner_valid <= 1'b0;
              r_winner_idx   <= '0;
              r_tie          <= 1'b0;
            end
          end
          ST_IDLE, ST_ARMED: begin
            if (i_session_done) begin
              // Close polling; any pending ballot or same-cycle vote is dropped
              r_state       <= ST_DONE;
              r_in_progress <= 1'b0;
              r_armed       <= 1'b0;
              r_done        <= 1'b1;
              r_scanning    <= 1'b1;
              r_scan_idx    <= '0;
              r_best_idx    <= '0;
              r_best_val    <= '0;
              r_tie_acc     <= 1'b0;
            end else if (r_state == ST_ARMED) begin
              if (w_onehot) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                  if (i_vote_btn[i]) begin
                    if (r_cnt[i] == c_CNT_MAX) r_overflow <= 1'b1;
                    else                       r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
                  end
                end
                r_state <= ST_IDLE;
                r_armed <= 1'b0;
              end else if (w_multi) begin
                r_invalid <= 1'b1;
              end
            end else if (i_ballot_arm) begin
              r_state <= ST_ARMED;
              r_armed <= 1'b1;
            end
          end
          ST_DONE: begin
            r_result <= w_disp_ok ? r_cnt[i_disp_sel] : '0;
            if (r_scanning) begin
              r_best_idx <= w_nxt_best_idx;
              r_best_val <= w_nxt_best_val;
              r_tie_acc  <= w_nxt_tie;
              if (r_scan_idx == c_LAST_IDX) begin
                r_scanning     <= 1'b0;
                r_winner_valid <= 1'b1;
                r_winner_idx   <= w_nxt_best_idx;
                r_tie          <= w_nxt_tie;
              end else begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
              end
            end
          end
          default: r_state <= ST_OFF;
        endcase
      end
    end
  end

  assign o_result_cnt         = r_result;
  assign o_winner_idx         = r_winner_idx;
  assign o_winner_valid       = r_winner_valid;
  assign o_tie                = r_tie;
  assign o_invalid_vote       = r_invalid;
  // Sticky flag stays stored across power-down but is hidden while OFF
  assign o_overflow           = r_overflow && (r_state != ST_OFF);
  assign o_voting_in_progress = r_in_progress;
  assign o_ballot_armed       = r_armed;
  assign o_voting_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_evm_multi_candidate.sv
`default_nettype none
// ============================================================================
// Module      : tb_evm_multi_candidate
// Description : Directed self-checking bench for evm_multi_candidate; a second
//               instance with CNT_W=2 exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evm_multi_candidate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  // Main instance (NUM_CAND=4, CNT_W=8)
  logic       switch_on = 0, switch_off = 0, ballot_arm = 0, session_done = 0;
  logic [3:0] vote_btn = '0;
  logic [1:0] disp_sel = '0;
  logic [7:0] result_cnt;
  logic [1:0] winner_idx;
  logic       winner_valid, tie, invalid_vote, overflow, in_prog, armed, vdone;

  // Saturation instance (NUM_CAND=4, CNT_W=2)
  logic       b_switch_on = 0, b_switch_off = 0, b_ballot_arm = 0, b_session_done = 0;
  logic [3:0] b_vote_btn = '0;
  logic [1:0] b_disp_sel = '0;
  logic [1:0] b_result_cnt;
  logic [1:0] b_winner_idx;
  logic       b_winner_valid, b_tie, b_invalid_vote, b_overflow, b_in_prog, b_armed, b_vdone;

  always #5 clk = ~clk;

  evm_multi_candidate #(.NUM_CAND(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_switch_on(switch_on), .i_switch_off(switch_off),
    .i_ballot_arm(ballot_arm), .i_vote_btn(vote_btn), .i_session_done(session_done),
    .i_disp_sel(disp_sel), .o_result_cnt(result_cnt), .o_winner_idx(winner_idx),
    .o_winner_valid(winner_valid), .o_tie(tie), .o_invalid_vote(invalid_vote),
    .o_overflow(overflow), .o_voting_in_progress(in_prog), .o_ballot_armed(armed),
    .o_voting_done(vdone)
  );

  evm_multi_candidate #(.NUM_CAND(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_switch_on(b_switch_on), .i_switch_off(b_switch_off),
    .i_ballot_arm(b_ballot_arm), .i_vote_btn(b_vote_btn), .i_session_done(b_session_done),
    .i_disp_sel(b_disp_sel), .o_result_cnt(b_result_cnt), .o_winner_idx(b_winner_idx),
    .o_winner_valid(b_winner_valid), .o_tie(b_tie), .o_invalid_vote(b_invalid_vote),
    .o_overflow(b_overflow), .o_voting_in_progress(b_in_prog), .o_ballot_armed(b_armed),
    .o_voting_done(b_vdone)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm_vote(input logic [3:0] vec);
    ballot_arm = 1; tick();
    ballot_arm = 0; vote_btn = vec; tick();
    vote_btn = '0;
  endtask

  task automatic power_cycle();
    switch_off = 1; tick();
    switch_off = 0; switch_on = 1; tick();
    switch_on = 0;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if ({result_cnt, winner_valid, in_prog, armed, vdone, overflow} !== 13'd0)
      $display("FAIL reset_async outputs got=%h exp=0", {result_cnt, winner_valid, in_prog, armed, vdone, overflow}); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick();
    n_total++; if ({winner_idx, tie, invalid_vote, in_prog, vdone} !== 6'd0)
      $display("FAIL reset_hold outputs got=%h exp=0", {winner_idx, tie, invalid_vote, in_prog, vdone}); else n_pass++;
  endtask

  task automatic test_single_winner();
    switch_on = 1; tick(); switch_on = 0;
    n_total++; if (in_prog !== 1'b1) $display("FAIL power_on in_progress got=%b exp=1", in_prog); else n_pass++;
    repeat (3) arm_vote(4'b0010);
    session_done = 1; tick(); session_done = 0; disp_sel = 2'd1;
    n_total++; if ({vdone, in_prog, winner_valid, winner_idx} !== 5'b10000)
      $display("FAIL done_cycle1 flags got=%b exp=10000", {vdone, in_prog, winner_valid, winner_idx}); else n_pass++;
    tick(3);
    n_total++; if (winner_valid !== 1'b0) $display("FAIL scan_cycle4 valid got=%b exp=0", winner_valid); else n_pass++;
    tick();
    n_total++; if ({winner_valid, winner_idx, tie} !== 4'b1010)
      $display("FAIL scan_cycle5 valid/idx/tie got=%b exp=1010", {winner_valid, winner_idx, tie}); else n_pass++;
    n_total++; if (result_cnt !== 8'd3) $display("FAIL tally_cand1 got=%0d exp=3", result_cnt); else n_pass++;
  endtask

  task automatic test_multi_press();
    power_cycle();
    ballot_arm = 1; tick(); ballot_arm = 0;
    n_total++; if (armed !== 1'b1) $display("FAIL arm ballot_armed got=%b exp=1", armed); else n_pass++;
    vote_btn = 4'b0110; tick(); vote_btn = '0;
    n_total++; if ({invalid_vote, armed} !== 2'b11)
      $display("FAIL multi_press invalid/armed got=%b exp=11", {invalid_vote, armed}); else n_pass++;
    tick();
    n_total++; if ({invalid_vote, armed} !== 2'b01)
      $display("FAIL pulse_width invalid/armed got=%b exp=01", {invalid_vote, armed}); else n_pass++;
    vote_btn = 4'b0100; tick(); vote_btn = '0;
    n_total++; if ({armed, in_prog} !== 2'b01)
      $display("FAIL vote_to_idle armed/in_prog got=%b exp=01", {armed, in_prog}); else n_pass++;
    session_done = 1; tick(); session_done = 0;
    disp_sel = 2'd2; tick(2);
    n_total++; if (result_cnt !== 8'd1) $display("FAIL tally_cand2 got=%0d exp=1", result_cnt); else n_pass++;
    disp_sel = 2'd1; tick();
    n_total++; if (result_cnt !== 8'd0) $display("FAIL tally_cand1_after_reject got=%0d exp=0", result_cnt); else n_pass++;
  endtask

  task automatic test_idle_ignore();
    power_cycle();
    vote_btn = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if ({invalid_vote, armed} !== 2'b00)
        $display("FAIL idle_vote_%0d invalid/armed got=%b exp=00", i, {invalid_vote, armed}); else n_pass++;
    end
    vote_btn = '0;
    session_done = 1; tick(); session_done = 0; disp_sel = 2'd0; tick(2);
    n_total++; if (result_cnt !== 8'd0) $display("FAIL idle_tally_cand0 got=%0d exp=0", result_cnt); else n_pass++;
  endtask

  task automatic test_tie();
    power_cycle();
    arm_vote(4'b0001); arm_vote(4'b0001);
    arm_vote(4'b1000); arm_vote(4'b1000);
    session_done = 1; tick(); session_done = 0; tick(4);
    n_total++; if ({winner_valid, winner_idx, tie} !== 4'b1001)
      $display("FAIL tie_0_3 valid/idx/tie got=%b exp=1001", {winner_valid, winner_idx, tie}); else n_pass++;
    switch_off = 1; tick(); switch_off = 0;
    n_total++; if ({winner_valid, tie, vdone, result_cnt} !== 11'd0)
      $display("FAIL off_hides got=%h exp=0", {winner_valid, tie, vdone, result_cnt}); else n_pass++;
    switch_on = 1; tick(); switch_on = 0;
    session_done = 1; tick(); session_done = 0; tick(4);
    n_total++; if ({winner_valid, winner_idx, tie} !== 4'b1001)
      $display("FAIL tie_all_zero valid/idx/tie got=%b exp=1001", {winner_valid, winner_idx, tie}); else n_pass++;
  endtask

  task automatic test_saturation();
    b_switch_on = 1; tick(); b_switch_on = 0;
    for (int v = 0; v < 4; v++) begin
      b_ballot_arm = 1; tick(); b_ballot_arm = 0;
      b_vote_btn = 4'b0010; tick(); b_vote_btn = '0;
      if (v == 2) begin
        n_total++; if (b_overflow !== 1'b0) $display("FAIL sat_at_max overflow got=%b exp=0", b_overflow); else n_pass++;
      end
    end
    n_total++; if (b_overflow !== 1'b1) $display("FAIL sat_overflow got=%b exp=1", b_overflow); else n_pass++;
    b_session_done = 1; tick(); b_session_done = 0; b_disp_sel = 2'd1; tick(2);
    n_total++; if (b_result_cnt !== 2'd3) $display("FAIL sat_tally got=%0d exp=3", b_result_cnt); else n_pass++;
    b_switch_off = 1; tick(); b_switch_off = 0;
    n_total++; if ({b_overflow, b_result_cnt} !== 3'd0)
      $display("FAIL sat_off_hidden got=%b exp=000", {b_overflow, b_result_cnt}); else n_pass++;
    b_switch_on = 1; tick(); b_switch_on = 0;
    n_total++; if (b_overflow !== 1'b0) $display("FAIL sat_cleared overflow got=%b exp=0", b_overflow); else n_pass++;
    b_session_done = 1; tick(); b_session_done = 0; tick(2);
    n_total++; if (b_result_cnt !== 2'd0) $display("FAIL sat_cleared tally got=%0d exp=0", b_result_cnt); else n_pass++;
  endtask

  task automatic test_done_drop_and_reset();
    power_cycle();
    ballot_arm = 1; tick(); ballot_arm = 0;
    session_done = 1; vote_btn = 4'b0001; tick(); session_done = 0; vote_btn = '0;
    n_total++; if ({vdone, armed, invalid_vote} !== 3'b100)
      $display("FAIL done_same_cycle flags got=%b exp=100", {vdone, armed, invalid_vote}); else n_pass++;
    disp_sel = 2'd0; tick(2);
    n_total++; if (result_cnt !== 8'd0) $display("FAIL dropped_vote tally got=%0d exp=0", result_cnt); else n_pass++;
    n_total++; if (winner_valid !== 1'b0) $display("FAIL mid_scan valid got=%b exp=0", winner_valid); else n_pass++;
    rst_n = 1'b0; #2;
    n_total++; if ({vdone, in_prog, armed, winner_valid, tie, winner_idx, result_cnt, overflow} !== 16'd0)
      $display("FAIL async_reset outputs got=%h exp=0", {vdone, in_prog, armed, winner_valid, tie, winner_idx, result_cnt, overflow}); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick(2);
    n_total++; if ({vdone, in_prog} !== 2'b00)
      $display("FAIL reset_to_off state got=%b exp=00", {vdone, in_prog}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_multi_press();
    test_idle_ignore();
    test_tie();
    test_saturation();
    test_done_drop_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
